// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC seven-segment reader: segment patterns,
// FSM state encoding and the default stability window.
package tdc_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 4;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // EMPTY: nothing accepted since reset; SETTLE: counting a new pair;
  // LOCKED: the current pair has already been accepted or rejected
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } tdc_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one seven-segment digit into BCD plus a flag
// telling whether the pattern is one of the ten decimal glyphs.
module seg7_to_bcd
  import tdc_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal
);

  // Exact-match lookup; anything else is reported illegal with digit 0
  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/tdc_seg_reader.sv
// Reads a two-digit seven-segment display, debounces it over STABLE_CYCLES
// identical samples, and reports accepted values, sequence breaks (each
// value is expected to be the previous + 1 mod 100) and illegal glyphs.
// There is no handshake: all status outputs are single-cycle pulses or
// level outputs that the consumer samples every cycle.
module tdc_seg_reader
  import tdc_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       value_valid,
  output logic       seq_error,
  output logic       illegal,
  output logic       illegal_flag,
  output logic [7:0] error_count,
  output tdc_state_e dbg_state
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  tdc_state_e  state, state_nxt;
  logic [13:0] sample;      // {seg1,seg0} captured every cycle
  logic [13:0] lock_pair;   // pair last accepted or rejected
  logic [7:0]  cnt;         // consecutive identical samples, saturating
  logic        first;       // no legal value accepted since reset

  logic [3:0]  dig1, dig0;
  logic        legal1, legal0;
  logic [3:0]  inc1, inc0;
  logic        accept, reject, seq_bad;

  seg7_to_bcd u_dec1 (.seg(sample[13:7]), .digit(dig1), .legal(legal1));
  seg7_to_bcd u_dec0 (.seg(sample[6:0]),  .digit(dig0), .legal(legal0));

  assign dbg_state = state;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next state and accept/reject decisions, all from the sample register
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      ST_EMPTY:  state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (cnt == STABLE_MAX) begin
          state_nxt = ST_LOCKED;
          if (legal1 && legal0) accept = 1'b1;
          else                  reject = 1'b1;
        end
      end
      ST_LOCKED: if (sample != lock_pair) state_nxt = ST_SETTLE;
      default:   state_nxt = ST_EMPTY;
    endcase
  end

  // Expected successor of the current value (99 wraps to 00) and the check
  always_comb begin
    inc0 = (bcd0 == 4'd9) ? 4'd0 : bcd0 + 4'd1;
    inc1 = bcd1;
    if (bcd0 == 4'd9) inc1 = (bcd1 == 4'd9) ? 4'd0 : bcd1 + 4'd1;
    seq_bad = accept && !first && ({dig1, dig0} != {inc1, inc0});
  end

  // Sampling, stability counting, value registers and error bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample       <= '0;
      cnt          <= '0;
      lock_pair    <= '0;
      first        <= 1'b1;
      bcd1         <= '0;
      bcd0         <= '0;
      value_valid  <= 1'b0;
      seq_error    <= 1'b0;
      illegal      <= 1'b0;
      illegal_flag <= 1'b0;
      error_count  <= '0;
    end else begin
      sample <= {seg1, seg0};
      if ({seg1, seg0} != sample)  cnt <= 8'd1;
      else if (cnt != STABLE_MAX)  cnt <= cnt + 8'd1;

      value_valid <= accept;
      seq_error   <= seq_bad;
      illegal     <= reject;

      if (accept || reject) lock_pair <= sample;
      if (accept) begin
        bcd1  <= dig1;
        bcd0  <= dig0;
        first <= 1'b0;
      end
      if (reject) illegal_flag <= 1'b1;
      if ((seq_bad || reject) && error_count != 8'hFF)
        error_count <= error_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_tdc_seg_reader.sv
// Bench for tdc_seg_reader. The reference model thinks in "runs": maximal
// stretches of identical sampled pairs. Every run reaching STABLE_CYCLES
// samples produces exactly one decision, visible after the following edge.
module tb_tdc_seg_reader;
  import tdc_pkg::*;

  localparam int S = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg1 = 7'h3F;
  logic [6:0] seg0 = 7'h06;
  logic [3:0] bcd1, bcd0;
  logic       value_valid, seq_error, illegal, illegal_flag;
  logic [7:0] error_count;
  tdc_state_e dbg_state;

  tdc_seg_reader #(.STABLE_CYCLES(S)) dut (
    .clock(clock), .reset(reset), .seg1(seg1), .seg0(seg0),
    .bcd1(bcd1), .bcd0(bcd0), .value_valid(value_valid),
    .seq_error(seq_error), .illegal(illegal), .illegal_flag(illegal_flag),
    .error_count(error_count), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // ---------------- reference model ----------------
  logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [13:0] run_pair, pend_pair;
  int          run_len;
  logic        pending;
  logic        m_first, m_flag;
  int          m_value, m_count;
  logic        e_valid, e_seq, e_ill;
  logic [7:0]  exp_q[$];

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    run_len = 0; pending = 1'b0; run_pair = '0; pend_pair = '0;
    m_first = 1'b1; m_flag = 1'b0; m_value = 0; m_count = 0;
    e_valid = 1'b0; e_seq = 1'b0; e_ill = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_decide(input logic [13:0] pair);
    int d1, d0, v;
    d1 = decode(pair[13:7]);
    d0 = decode(pair[6:0]);
    if (d1 < 0 || d0 < 0) begin
      e_ill = 1'b1; m_flag = 1'b1;
      if (m_count < 255) m_count++;
    end else begin
      v = d1 * 10 + d0;
      e_valid = 1'b1;
      if (!m_first && v != (m_value + 1) % 100) begin
        e_seq = 1'b1;
        if (m_count < 255) m_count++;
      end
      m_first = 1'b0;
      m_value = v;
      exp_q.push_back({4'(d1), 4'(d0)});
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  // Drive one pair for one clock, advance the model, compare after the edge.
  task automatic step(input logic [6:0] s1, input logic [6:0] s0);
    logic [7:0] exp_v;
    seg1 = s1; seg0 = s0;
    @(posedge clock);
    e_valid = 1'b0; e_seq = 1'b0; e_ill = 1'b0;
    if (pending) model_decide(pend_pair);
    if (run_len > 0 && {s1, s0} == run_pair) run_len++;
    else begin run_pair = {s1, s0}; run_len = 1; end
    pending = (run_len == S);
    if (pending) pend_pair = run_pair;
    #1;
    checks++; if (value_valid !== e_valid) $display("FAIL value_valid t=%0t got %b exp %b", $time, value_valid, e_valid); else passes++;
    checks++; if (seq_error !== e_seq) $display("FAIL seq_error t=%0t got %b exp %b", $time, seq_error, e_seq); else passes++;
    checks++; if (illegal !== e_ill) $display("FAIL illegal t=%0t got %b exp %b", $time, illegal, e_ill); else passes++;
    checks++; if (illegal_flag !== m_flag) $display("FAIL illegal_flag t=%0t got %b exp %b", $time, illegal_flag, m_flag); else passes++;
    checks++; if (error_count !== 8'(m_count)) $display("FAIL error_count t=%0t got %0d exp %0d", $time, error_count, m_count); else passes++;
    checks++;
    if ({bcd1, bcd0} !== {4'(m_value / 10), 4'(m_value % 10)})
      $display("FAIL bcd t=%0t got %h%h exp %0d", $time, bcd1, bcd0, m_value);
    else passes++;
    if (value_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL accept_order t=%0t unexpected value %h%h", $time, bcd1, bcd0);
      else begin
        exp_v = exp_q.pop_front();
        if ({bcd1, bcd0} !== exp_v) $display("FAIL accept_order t=%0t got %h%h exp %h", $time, bcd1, bcd0, exp_v);
        else passes++;
      end
    end
    @(negedge clock);
  endtask

  task automatic hold(input int value, input int cycles);
    for (int i = 0; i < cycles; i++) step(seg_tab[value / 10], seg_tab[value % 10]);
  endtask

  // Asynchronous assertion, checked before any clock edge, then release
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bcd1, bcd0, value_valid, seq_error, illegal, illegal_flag, error_count} !== '0 || dbg_state !== ST_EMPTY)
      $display("FAIL reset_state t=%0t bcd=%h%h v=%b s=%b i=%b f=%b cnt=%0d st=%0d exp all 0",
               $time, bcd1, bcd0, value_valid, seq_error, illegal, illegal_flag, error_count, dbg_state);
    else passes++;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_first_value();
    int hit = -1;
    for (int i = 0; i < 6; i++) begin
      step(7'h3F, 7'h06);
      if (value_valid === 1'b1 && hit < 0) hit = i;
    end
    checks++; if (hit != S) $display("FAIL first_latency got step %0d exp %0d", hit, S); else passes++;
    checks++; if ({bcd1, bcd0} !== 8'h01) $display("FAIL first_value got %h%h exp 01", bcd1, bcd0); else passes++;
  endtask

  task automatic test_sweep();
    int nval = 0, nseq = 0;
    for (int v = 2; v <= 100; v++)
      for (int i = 0; i < 6; i++) begin
        step(seg_tab[(v % 100) / 10], seg_tab[v % 10]);
        if (value_valid === 1'b1) nval++;
        if (seq_error === 1'b1) nseq++;
      end
    checks++; if (nval != 99) $display("FAIL sweep_count got %0d exp 99", nval); else passes++;
    checks++; if (nseq != 0) $display("FAIL sweep_seq got %0d exp 0", nseq); else passes++;
    checks++; if ({bcd1, bcd0} !== 8'h00) $display("FAIL sweep_wrap got %h%h exp 00", bcd1, bcd0); else passes++;
  endtask

  task automatic test_seq_skip();
    apply_reset();
    hold(5, 6);
    hold(7, 6);
    checks++; if ({bcd1, bcd0} !== 8'h07) $display("FAIL skip_value got %h%h exp 07", bcd1, bcd0); else passes++;
    checks++; if (error_count !== 8'd1) $display("FAIL skip_count got %0d exp 1", error_count); else passes++;
  endtask

  task automatic test_glitch();
    int nval = 0, nseq = 0;
    hold(12, 6);
    for (int i = 0; i < 8; i++) begin
      if (i < 2) hold(13, 1); else hold(12, 1);
      if (value_valid === 1'b1) nval++;
      if (seq_error === 1'b1) nseq++;
    end
    checks++; if (nval != 1 || nseq != 1) $display("FAIL glitch_reaccept got v=%0d s=%0d exp 1/1", nval, nseq); else passes++;
    checks++; if ({bcd1, bcd0} !== 8'h12) $display("FAIL glitch_value got %h%h exp 12", bcd1, bcd0); else passes++;
  endtask

  task automatic test_illegal();
    int nill = 0, nval = 0;
    for (int i = 0; i < 6; i++) begin
      step(7'h00, 7'h7F);
      if (illegal === 1'b1) nill++;
      if (value_valid === 1'b1) nval++;
    end
    checks++; if (nill != 1 || nval != 0) $display("FAIL illegal_pulse got i=%0d v=%0d exp 1/0", nill, nval); else passes++;
    checks++; if (illegal_flag !== 1'b1 || {bcd1, bcd0} !== 8'h12) $display("FAIL illegal_hold got f=%b bcd=%h%h exp 1/12", illegal_flag, bcd1, bcd0); else passes++;
  endtask

  task automatic test_reset_mid_settle();
    hold(43, 6);
    hold(44, 2);
    #2;
    apply_reset();
    hold(44, 6);
    checks++;
    if ({bcd1, bcd0} !== 8'h44 || error_count !== 8'd0 || illegal_flag !== 1'b0)
      $display("FAIL reset_restart got bcd=%h%h cnt=%0d f=%b exp 44/0/0", bcd1, bcd0, error_count, illegal_flag);
    else passes++;
  endtask

  task automatic test_random();
    int sel, v;
    logic [6:0] r1, r0;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      v = (sel < 6) ? (m_value + 1) % 100 : $urandom_range(0, 99);
      r1 = seg_tab[v / 10];
      r0 = seg_tab[v % 10];
      if (sel == 9) r0 = 7'($urandom_range(0, 127));
      for (int i = $urandom_range(1, 7); i > 0; i--) step(r1, r0);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int n = 0; n < 135; n++) begin
      hold(5, 5);
      hold(7, 5);
    end
    checks++; if (error_count !== 8'd255) $display("FAIL saturate got %0d exp 255", error_count); else passes++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    model_reset();
    @(negedge clock);
    test_reset();
    test_first_value();
    test_sweep();
    test_seq_skip();
    test_glitch();
    test_illegal();
    test_reset_mid_settle();
    test_random();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) $display("FAIL accept_missing %0d values never reported", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tdc_seg_reader.md
TDC_SEG_READER -- requirements
Module: tdc_seg_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, legal range 2..255; consecutive identical samples required before a segment pair is accepted.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-004 seg1  input  7  tens-digit segment bus, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
REQ-005 seg0  input  7  units-digit segment bus, same encoding as seg1.
REQ-006 bcd1  output  4  tens digit of the last accepted legal pair.
REQ-007 bcd0  output  4  units digit of the last accepted legal pair.
REQ-008 value_valid  output  1  one-cycle pulse when bcd1/bcd0 take a new accepted value.
REQ-009 seq_error  output  1  one-cycle pulse when an accepted value is not the previous value + 1 (mod 100).
REQ-010 illegal  output  1  one-cycle pulse when a stable pair contains a non-decimal pattern.
REQ-011 illegal_flag  output  1  sticky; set with illegal, cleared only by reset.
REQ-012 error_count  output  8  count of seq_error plus illegal pulses, saturating at 255.

Function
REQ-013 Legal patterns SHALL be exactly 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); every other value is illegal.
REQ-014 {seg1,seg0} SHALL be registered once into a sample register each cycle; all decisions use the sample register only.
REQ-015 A stability counter SHALL reset to 1 whenever the sample differs from the previous sample and increment, saturating at STABLE_CYCLES, while it is unchanged.
REQ-016 FSM states: EMPTY (nothing accepted since reset), SETTLE (pair differs from last accepted pair, counting), LOCKED (current pair already accepted or rejected).
REQ-017 EMPTY -> SETTLE on the first sample after reset; SETTLE -> LOCKED when the counter reaches STABLE_CYCLES; LOCKED -> SETTLE when the sample differs from the locked pair.
REQ-018 On SETTLE -> LOCKED with both digits legal: bcd1/bcd0 SHALL update and value_valid pulse in the same cycle.
REQ-019 On SETTLE -> LOCKED with either digit illegal: illegal SHALL pulse, illegal_flag set, bcd1/bcd0 and the sequence reference unchanged, no value_valid.
REQ-020 Latency: a pair applied constantly at the inputs from edge t SHALL produce value_valid in the cycle after edge t+STABLE_CYCLES.
REQ-021 A pair changing before reaching STABLE_CYCLES SHALL be discarded silently; counting restarts on the new pair.
REQ-022 A pair returning to the currently locked value after a glitch shorter than STABLE_CYCLES SHALL be re-accepted, and value_valid SHALL pulse again.
REQ-023 The sequence check SHALL apply to every legal acceptance except the first after reset: seq_error pulses, together with value_valid, if new != (prev + 1) mod 100.
REQ-024 Wrap-around 99 -> 00 SHALL be legal; 00 following any value other than 99 SHALL raise seq_error.
REQ-025 An identical value accepted twice in succession (REQ-022) SHALL raise seq_error.
REQ-026 seq_error and illegal SHALL never pulse in the same cycle; error_count SHALL increment by exactly 1 per pulse and hold at 255.

Reset
REQ-027 While reset is low: bcd1 = 0, bcd0 = 0, all pulses 0, illegal_flag = 0, error_count = 0, state EMPTY, sample register = 0, stability counter = 0, the first-value marker set.
REQ-028 Reset asserted mid-SETTLE SHALL discard the pending pair; after release, acceptance SHALL restart from EMPTY with no sequence check on the first value.

Structure
REQ-029 Shared package tdc_pkg SHALL hold the ten segment constants, the FSM state encoding and the STABLE_CYCLES default.
REQ-030 Sub-module seg7_to_bcd (combinational: 7-bit pattern -> 4-bit digit + legal flag) SHALL be instantiated once per digit.
REQ-031 Target size: 120-400 lines of RTL, excluding the package.

Verification
REQ-032 Reset, then hold 3F/06 ("01") -> value_valid with bcd1=0, bcd0=1 in the cycle after edge t+4; seq_error=0.
REQ-033 Step 3F/5B, 3F/4F ... to 6F/6F and then 3F/3F, each held for 6 cycles -> 99 values accepted in order, no seq_error, including the 99 -> 00 wrap.
REQ-034 Locked "05", apply "07" for 6 cycles -> value_valid with bcd=0/7, seq_error pulse, error_count=1.
REQ-035 Locked "12", glitch to "13" for 2 cycles, then back to "12" -> no acceptance of "13", "12" re-accepted, seq_error pulse.
REQ-036 Hold seg0=7F, seg1=00 for 6 cycles -> illegal pulse, illegal_flag=1, bcd unchanged, no value_valid.
REQ-037 Assert reset during SETTLE of "44", then release -> all outputs 0; next stable "44" accepted with no seq_error.
